// File: rtl/mac_sequencer_pkg.sv
// Shared opcode constants and state encodings for the mac command sequencer.
package mac_sequencer_pkg;

  localparam int unsigned OPCODE_WIDTH = 4;

  // Opcodes understood by the mac unit; MAC_LSW doubles as the harmless idle opcode.
  localparam logic [OPCODE_WIDTH-1:0] MAC_RESET = 4'h1;
  localparam logic [OPCODE_WIDTH-1:0] MAC_REGA  = 4'h2;
  localparam logic [OPCODE_WIDTH-1:0] MAC_REGB  = 4'h3;
  localparam logic [OPCODE_WIDTH-1:0] MAC_MULT  = 4'h4;
  localparam logic [OPCODE_WIDTH-1:0] MAC_ACC   = 4'h5;
  localparam logic [OPCODE_WIDTH-1:0] MAC_MSW   = 4'h6;
  localparam logic [OPCODE_WIDTH-1:0] MAC_LSW   = 4'h7;

  typedef enum logic [3:0] {
    MSEQ_IDLE  = 4'd0,
    MSEQ_CLR   = 4'd1,
    MSEQ_FETCH = 4'd2,
    MSEQ_LDA   = 4'd3,
    MSEQ_LDB   = 4'd4,
    MSEQ_MUL   = 4'd5,
    MSEQ_ACC   = 4'd6,
    MSEQ_RDM   = 4'd7,
    MSEQ_WM    = 4'd8,
    MSEQ_RDL   = 4'd9,
    MSEQ_WL    = 4'd10,
    MSEQ_DONE  = 4'd11
  } mseq_state_e;

endpackage

// File: rtl/mac_sequencer.sv
// Drives the mac unit through clear / load / multiply / accumulate for each operand
// pair, then reads the accumulator back and returns it on a valid/ready port.
module mac_sequencer
  import mac_sequencer_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = 8,
  parameter int unsigned LEN_WIDTH  = 8,
  parameter int unsigned RD_LAT     = 1
) (
  input  logic                      clk,
  input  logic                      a_reset,
  input  logic                      start,
  input  logic [LEN_WIDTH-1:0]      length,
  output logic                      busy,
  input  logic                      in_valid,
  output logic                      in_ready,
  input  logic [DATA_WIDTH-1:0]     in_a,
  input  logic [DATA_WIDTH-1:0]     in_b,
  output logic [OPCODE_WIDTH-1:0]   mac_opcode,
  output logic [DATA_WIDTH-1:0]     mac_data_in,
  input  logic [DATA_WIDTH-1:0]     mac_data_out,
  input  logic                      mac_acc_overflow,
  output logic                      res_valid,
  input  logic                      res_ready,
  output logic [2*DATA_WIDTH-1:0]   result,
  output logic                      res_overflow
);

  localparam int unsigned WAIT_W = (RD_LAT > 1) ? $clog2(RD_LAT) : 1;

  mseq_state_e            state;
  logic [LEN_WIDTH-1:0]   pairs_left;
  logic [WAIT_W-1:0]      wait_cnt;
  logic [DATA_WIDTH-1:0]  b_hold;

  // Opcode/data are assigned for the state being entered, so they line up with it.
  always_ff @(posedge clk or posedge a_reset) begin
    if (a_reset) begin
      state        <= MSEQ_IDLE;
      pairs_left   <= '0;
      wait_cnt     <= '0;
      b_hold       <= '0;
      mac_opcode   <= MAC_LSW;
      mac_data_in  <= '0;
      in_ready     <= 1'b0;
      busy         <= 1'b0;
      res_valid    <= 1'b0;
      res_overflow <= 1'b0;
      result       <= '0;
    end else begin
      mac_opcode  <= MAC_LSW;
      mac_data_in <= '0;
      case (state)
        MSEQ_IDLE: begin
          if (start) begin
            state      <= MSEQ_CLR;
            pairs_left <= length;
            busy       <= 1'b1;
            mac_opcode <= MAC_RESET;
          end
        end
        MSEQ_CLR: begin
          if (pairs_left != '0) begin
            state    <= MSEQ_FETCH;
            in_ready <= 1'b1;
          end else begin
            state      <= MSEQ_RDM;
            mac_opcode <= MAC_MSW;
          end
        end
        MSEQ_FETCH: begin
          if (in_valid) begin
            state       <= MSEQ_LDA;
            in_ready    <= 1'b0;
            mac_opcode  <= MAC_REGA;
            mac_data_in <= in_a;
            b_hold      <= in_b;
          end
        end
        MSEQ_LDA: begin
          state       <= MSEQ_LDB;
          mac_opcode  <= MAC_REGB;
          mac_data_in <= b_hold;
        end
        MSEQ_LDB: begin
          state      <= MSEQ_MUL;
          mac_opcode <= MAC_MULT;
        end
        MSEQ_MUL: begin
          state      <= MSEQ_ACC;
          mac_opcode <= MAC_ACC;
        end
        MSEQ_ACC: begin
          pairs_left <= pairs_left - LEN_WIDTH'(1);
          if (pairs_left != LEN_WIDTH'(1)) begin
            state    <= MSEQ_FETCH;
            in_ready <= 1'b1;
          end else begin
            state      <= MSEQ_RDM;
            mac_opcode <= MAC_MSW;
          end
        end
        MSEQ_RDM: begin
          state    <= MSEQ_WM;
          wait_cnt <= WAIT_W'(RD_LAT - 1);
        end
        MSEQ_WM: begin
          if (wait_cnt == '0) begin
            result[2*DATA_WIDTH-1:DATA_WIDTH] <= mac_data_out;
            state      <= MSEQ_RDL;
            mac_opcode <= MAC_LSW;
          end else begin
            wait_cnt <= wait_cnt - WAIT_W'(1);
          end
        end
        MSEQ_RDL: begin
          state    <= MSEQ_WL;
          wait_cnt <= WAIT_W'(RD_LAT - 1);
        end
        MSEQ_WL: begin
          if (wait_cnt == '0) begin
            result[DATA_WIDTH-1:0] <= mac_data_out;
            res_overflow <= mac_acc_overflow;
            res_valid    <= 1'b1;
            state        <= MSEQ_DONE;
          end else begin
            wait_cnt <= wait_cnt - WAIT_W'(1);
          end
        end
        MSEQ_DONE: begin
          if (res_ready) begin
            res_valid <= 1'b0;
            busy      <= 1'b0;
            state     <= MSEQ_IDLE;
          end
        end
        default: begin
          state     <= MSEQ_IDLE;
          in_ready  <= 1'b0;
          busy      <= 1'b0;
          res_valid <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mac_sequencer.sv
// Directed bench for mac_sequencer driving a small behavioural mac model.
module tb_mac_sequencer;
  import mac_sequencer_pkg::*;

  logic        clk = 1'b0;
  logic        a_reset;
  logic        start;
  logic [7:0]  length;
  logic        busy;
  logic        in_valid;
  logic        in_ready;
  logic [7:0]  in_a;
  logic [7:0]  in_b;
  logic [3:0]  mac_opcode;
  logic [7:0]  mac_data_in;
  logic [7:0]  mac_data_out;
  logic        mac_acc_overflow;
  logic        res_valid;
  logic        res_ready;
  logic [15:0] result;
  logic        res_overflow;

  int checks = 0;
  int failures = 0;
  logic [7:0] pa [8];
  logic [7:0] pb [8];

  always #5 clk = ~clk;

  mac_sequencer #(.DATA_WIDTH(8), .LEN_WIDTH(8), .RD_LAT(1)) dut (
    .clk(clk), .a_reset(a_reset), .start(start), .length(length), .busy(busy),
    .in_valid(in_valid), .in_ready(in_ready), .in_a(in_a), .in_b(in_b),
    .mac_opcode(mac_opcode), .mac_data_in(mac_data_in), .mac_data_out(mac_data_out),
    .mac_acc_overflow(mac_acc_overflow), .res_valid(res_valid), .res_ready(res_ready),
    .result(result), .res_overflow(res_overflow)
  );

  // Behavioural mac: one-cycle readback, sticky overflow cleared only by MAC_RESET.
  logic [7:0]  m_a = '0;
  logic [7:0]  m_b = '0;
  logic [15:0] m_prod = '0;
  logic [15:0] m_acc = '0;
  logic        m_ovf = 1'b0;
  logic [7:0]  m_dout = '0;
  logic [16:0] m_sum;
  assign m_sum = {1'b0, m_acc} + {1'b0, m_prod};
  assign mac_data_out = m_dout;
  assign mac_acc_overflow = m_ovf;

  always @(posedge clk) begin
    case (mac_opcode)
      MAC_RESET: begin m_a <= '0; m_b <= '0; m_prod <= '0; m_acc <= '0; m_ovf <= 1'b0; end
      MAC_REGA:  m_a <= mac_data_in;
      MAC_REGB:  m_b <= mac_data_in;
      MAC_MULT:  m_prod <= m_a * m_b;
      MAC_ACC:   begin m_acc <= m_sum[15:0]; m_ovf <= m_ovf | m_sum[16]; end
      MAC_MSW:   m_dout <= m_acc[15:8];
      MAC_LSW:   m_dout <= m_acc[7:0];
      default:   ;
    endcase
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic set_basic();
    pa[0] = 8'h0F; pb[0] = 8'h1A;
    pa[1] = 8'h26; pb[1] = 8'h05;
    pa[2] = 8'h03; pb[2] = 8'h11;
  endtask

  task automatic set_ovf();
    pa[0] = 8'hFF; pb[0] = 8'hFE;
    pa[1] = 8'hFD; pb[1] = 8'hFC;
  endtask

  // Runs one job; abort_cyc>0 asserts reset in that cycle and checks reset values.
  task automatic run_job(input string tag, input int n, input bit stall_en, input int hold,
                         input int abort_cyc, input logic [15:0] exp_res, input logic exp_ovf);
    int cyc;
    int idx;
    int stalls;
    bit stall;
    bit fire;
    @(negedge clk);
    start = 1'b1; length = 8'(n); res_ready = 1'b0;
    @(posedge clk); #1;
    start = 1'b0;
    cyc = 1; idx = 0; stalls = 0;
    check({tag, "_busy_c1"}, 32'(busy), 32'd1);
    check({tag, "_op_clr"}, 32'(mac_opcode), 32'(MAC_RESET));
    while (!res_valid && cyc < 400) begin
      @(negedge clk);
      stall = stall_en && (cyc % 3 == 2);
      in_valid = !stall;
      in_a = pa[idx % 8];
      in_b = pb[idx % 8];
      if (in_ready && stall) begin
        stalls++;
        check({tag, "_stall_op"}, 32'(mac_opcode), 32'(MAC_LSW));
      end
      fire = in_ready && in_valid;
      @(posedge clk);
      if (fire) idx++;
      #1 cyc++;
      if (abort_cyc != 0 && cyc == abort_cyc) begin
        check({tag, "_op_mul"}, 32'(mac_opcode), 32'(MAC_MULT));
        #1 a_reset = 1'b1;
        #1;
        check({tag, "_rst_op"}, 32'(mac_opcode), 32'(MAC_LSW));
        check({tag, "_rst_din"}, 32'(mac_data_in), 32'd0);
        check({tag, "_rst_ctl"}, {28'd0, in_ready, busy, res_valid, res_overflow}, 32'd0);
        check({tag, "_rst_res"}, 32'(result), 32'd0);
        @(negedge clk);
        a_reset = 1'b0; in_valid = 1'b0;
        return;
      end
    end
    in_valid = 1'b0;
    check({tag, "_done_cyc"}, 32'(cyc), 32'(5 * n + 6 + stalls));
    check({tag, "_pairs"}, 32'(idx), 32'(n));
    check({tag, "_result"}, 32'(result), 32'(exp_res));
    check({tag, "_ovf"}, 32'(res_overflow), 32'(exp_ovf));
    check({tag, "_done_op"}, {27'd0, in_ready, mac_opcode}, 32'(MAC_LSW));
    repeat (hold) begin
      @(negedge clk);
      start = 1'b1; length = 8'd5;
      @(posedge clk); #1;
      check({tag, "_hold_valid"}, 32'(res_valid), 32'd1);
      check({tag, "_hold_res"}, {15'd0, res_overflow, result}, {15'd0, exp_ovf, exp_res});
    end
    @(negedge clk);
    start = 1'b0; res_ready = 1'b1;
    @(posedge clk); #1;
    check({tag, "_hs_valid"}, 32'(res_valid), 32'd0);
    check({tag, "_hs_busy"}, 32'(busy), 32'd0);
    @(negedge clk);
    res_ready = 1'b0;
  endtask

  initial begin
    a_reset = 1'b1; start = 1'b0; length = '0; in_valid = 1'b0;
    in_a = '0; in_b = '0; res_ready = 1'b0;
    for (int i = 0; i < 8; i++) begin pa[i] = '0; pb[i] = '0; end
    repeat (2) @(posedge clk);
    #1;
    check("reset_op", 32'(mac_opcode), 32'(MAC_LSW));
    check("reset_din", 32'(mac_data_in), 32'd0);
    check("reset_ctl", {28'd0, in_ready, busy, res_valid, res_overflow}, 32'd0);
    check("reset_res", 32'(result), 32'd0);
    @(negedge clk);
    a_reset = 1'b0;

    set_basic();
    run_job("basic", 3, 1'b0, 0, 0, 16'h0277, 1'b0);
    set_ovf();
    run_job("ovf", 2, 1'b0, 0, 0, 16'hF60E, 1'b1);
    set_basic();
    run_job("b2b", 3, 1'b0, 0, 0, 16'h0277, 1'b0);
    run_job("stall", 3, 1'b1, 0, 0, 16'h0277, 1'b0);
    run_job("zero", 0, 1'b0, 5, 0, 16'h0000, 1'b0);
    repeat (2) begin
      @(posedge clk); #1;
      check("start_ignored", {30'd0, busy, in_ready}, 32'd0);
    end
    run_job("abort", 3, 1'b0, 0, 10, 16'h0277, 1'b0);
    run_job("post_rst", 3, 1'b0, 0, 0, 16'h0277, 1'b0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
